// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 demultiplexing router.
package demux_pkg;

  localparam int NUM_CH         = 4;
  localparam int STAT_W         = 16;
  localparam int DEFAULT_DATA_W = 8;

  typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/demux_ch_fifo.sv
// Per-channel synchronous FIFO; storage is cleared on reset so the head reads zero when empty.
module demux_ch_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  // A full FIFO refuses a push even if it pops in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == CNT_MAX);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/demux_router_1to4.sv
// 1-to-4 router: select decode, in_ready mux, output packing, optional pop counters.
// Optional feature macro: DEMUX_STATS_EN adds the out_cnt port and saturating pop counters.
module demux_router_1to4
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  ch_sel_t                  in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] out_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [CNT_W-1:0]  w_count [NUM_CH];

  // Only the addressed channel's full flag gates the input; other channels never stall.
  assign in_ready = !rst && !w_full[in_sel];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_push[g]    = in_valid && in_ready && (in_sel == ch_sel_t'(g));
    assign w_pop[g]     = out_ready[g] && !w_empty[g];
    assign out_valid[g] = (w_count[g] != '0);

    demux_ch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[g]),
      .pop   (w_pop[g]),
      .wdata (in_data),
      .rdata (out_data[g*DATA_W +: DATA_W]),
      .full  (w_full[g]),
      .empty (w_empty[g]),
      .count (w_count[g])
    );
  end

`ifdef DEMUX_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = 1;

  logic [STAT_W-1:0] r_pop_cnt [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
    // Saturating so a long-running channel reads all-ones instead of wrapping.
    always_ff @(posedge clk) begin
      if (rst)                                   r_pop_cnt[g] <= '0;
      else if (w_pop[g] && (r_pop_cnt[g] != '1)) r_pop_cnt[g] <= r_pop_cnt[g] + STAT_ONE;
    end
    assign out_cnt[g*STAT_W +: STAT_W] = r_pop_cnt[g];
  end
`endif

endmodule

// File: tb/tb_demux_router_1to4.sv
// Directed self-checking bench for demux_router_1to4 (stats checks active with DEMUX_STATS_EN).
module tb_demux_router_1to4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel    = 2'd0;
  logic [7:0]  in_data   = 8'd0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'd0;
  logic [31:0] out_data;
`ifdef DEMUX_STATS_EN
  logic [63:0] out_cnt;
`endif

  int checks = 0;
  int errors = 0;

  demux_router_1to4 #(
    .DATA_W (8),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_STATS_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s,
                               input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset, including a push offered while reset is held
    tick();
    tick();
    applyStimulus(1'b1, 2'd2, 8'hFF, 4'b0000);
    checkOutput("rst_in_ready", in_ready, 0);
    tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Single word to channel 2
    applyStimulus(1'b1, 2'd2, 8'hA5, 4'b0000);
    checkOutput("a5_in_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("a5_out_valid", out_valid, 4'b0100);
    checkOutput("a5_out_data", out_data[23:16], 8'hA5);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0100);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("a5_drained", out_valid, 0);

    // Fill channel 1, then backpressure on it only
    applyStimulus(1'b1, 2'd1, 8'h11, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h22, 4'b0000);
    checkOutput("fill_second_ready", in_ready, 1);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h33, 4'b0000);
    checkOutput("full_in_ready", in_ready, 0);
    tick();
    applyStimulus(1'b1, 2'd0, 8'h44, 4'b0000);
    checkOutput("other_ch_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("fill_out_valid", out_valid, 4'b0011);
    checkOutput("fill_ch0_data", out_data[7:0], 8'h44);
    checkOutput("fill_ch1_head", out_data[15:8], 8'h11);

    // Full channel popping with a push offered: push waits a cycle
    applyStimulus(1'b1, 2'd1, 8'h33, 4'b0010);
    checkOutput("full_pop_ready", in_ready, 0);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h33, 4'b0000);
    checkOutput("freed_ready", in_ready, 1);
    checkOutput("order_2nd", out_data[15:8], 8'h22);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0010);
    checkOutput("order_2nd_again", out_data[15:8], 8'h22);
    tick();
    checkOutput("order_3rd", out_data[15:8], 8'h33);
    checkOutput("order_3rd_valid", out_valid, 4'b0011);
    tick();
    checkOutput("ch1_drained", out_valid, 4'b0001);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0001);
    tick();
    checkOutput("all_drained", out_valid, 0);

    // Round-robin streaming with every consumer ready
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, i[1:0], i[7:0], 4'hF);
      checkOutput("rr_in_ready", in_ready, 1);
      if (i > 0) begin
        checkOutput("rr_valid", out_valid, 4'b0001 << ((i - 1) % 4));
        checkOutput("rr_data", out_data[((i - 1) % 4) * 8 +: 8], i - 1);
      end
      tick();
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
    checkOutput("rr_last_valid", out_valid, 4'b1000);
    checkOutput("rr_last_data", out_data[31:24], 8'h3F);
    tick();
    checkOutput("rr_drained", out_valid, 0);
`ifdef DEMUX_STATS_EN
    checkOutput("rr_cnt0", out_cnt[15:0], 16);
    checkOutput("rr_cnt1", out_cnt[31:16], 16);
    checkOutput("rr_cnt2", out_cnt[47:32], 16);
    checkOutput("rr_cnt3", out_cnt[63:48], 16);
`endif

    // Mid-stream reset with a push and pops presented in the reset cycle
    applyStimulus(1'b1, 2'd3, 8'hC1, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd3, 8'hC2, 4'b0000);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("mid_buffered", out_valid, 4'b1000);
    checkOutput("mid_head", out_data[31:24], 8'hC1);
    rst = 1'b1;
    applyStimulus(1'b1, 2'd3, 8'hDD, 4'hF);
    checkOutput("mid_rst_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
    checkOutput("mid_out_valid", out_valid, 0);
    checkOutput("mid_out_data", out_data, 0);
    checkOutput("mid_in_ready", in_ready, 1);
`ifdef DEMUX_STATS_EN
    checkOutput("mid_cnt", out_cnt, 0);
`endif
    tick();
    tick();
    checkOutput("mid_no_stale", out_valid, 0);

`ifdef DEMUX_STATS_EN
    // Saturation of channel 0 pop counter
    applyStimulus(1'b1, 2'd0, 8'h5A, 4'b0001);
    repeat (65540) tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0001);
    tick();
    tick();
    checkOutput("sat_cnt0", out_cnt[15:0], 16'hFFFF);
    checkOutput("sat_cnt1", out_cnt[31:16], 0);
    checkOutput("sat_drained", out_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
